// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer.
// Holds the state encoding, lamp one-hot patterns and prescaler width helper.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_RED    = 2'b10
    } state_t;

    // Lamp patterns ordered {red, ylw, grn}
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // Width of a counter spanning 0..div-1; never narrower than one bit
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1, pulses tick on the last count.
// Ports: clk, rst (sync, active-high), clr (restart count at 0), tick (1-cycle pulse).
module tick_prescaler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = presc_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Vehicle traffic-light sequencer GREEN -> YELLOW -> RED with per-state dwell in ticks.
// Ports: clk, rst (sync, active-high), ped_req (async button), red/ylw/grn lamps,
//   sec_left (ticks remaining minus 1), ped_waiting (latched request).
// Optional macro TRAFFIC_PED_REQ_EN enables the pedestrian request that shortens GREEN.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV      = 100000000,
    parameter int GREEN_SEC     = 10,
    parameter int YELLOW_SEC    = 3,
    parameter int RED_SEC       = 8,
    parameter int MIN_GREEN_SEC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic       red_trffc_light,
    output logic       ylw_trffc_light,
    output logic       grn_trffc_light,
    output logic [7:0] sec_left,
    output logic       ped_waiting
);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("TICK_DIV must be >= 2");
    end
    if (GREEN_SEC < 1 || GREEN_SEC > 255) begin : g_bad_green
        $error("GREEN_SEC must be in 1..255");
    end
    if (YELLOW_SEC < 1 || YELLOW_SEC > 255) begin : g_bad_yellow
        $error("YELLOW_SEC must be in 1..255");
    end
    if (RED_SEC < 1 || RED_SEC > 255) begin : g_bad_red
        $error("RED_SEC must be in 1..255");
    end
    if (MIN_GREEN_SEC < 1 || MIN_GREEN_SEC > GREEN_SEC) begin : g_bad_min
        $error("MIN_GREEN_SEC must be in 1..GREEN_SEC");
    end

    localparam logic [7:0] G_LD = 8'(GREEN_SEC - 1);
    localparam logic [7:0] Y_LD = 8'(YELLOW_SEC - 1);
    localparam logic [7:0] R_LD = 8'(RED_SEC - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] next_load;
    logic [7:0] sec_cnt;
    logic [2:0] lamps;
    logic       tick;
    logic       ped_go;
    logic       advance;
    logic       pw;

    always_comb begin
        next_state = ST_GREEN;
        next_load  = G_LD;
        unique case (state)
            ST_GREEN: begin
                next_state = ST_YELLOW;
                next_load  = Y_LD;
            end
            ST_YELLOW: begin
                next_state = ST_RED;
                next_load  = R_LD;
            end
            default: begin
                next_state = ST_GREEN;
                next_load  = G_LD;
            end
        endcase
    end

`ifdef TRAFFIC_PED_REQ_EN
    logic       sync1;
    logic       sync2;
    logic [8:0] elapsed;

    // sec_cnt never exceeds GREEN_SEC-1 while in GREEN, so this cannot underflow
    assign elapsed = 9'(GREEN_SEC) - {1'b0, sec_cnt};
    assign ped_go  = (state == ST_GREEN) && pw
                     && (elapsed >= 9'(MIN_GREEN_SEC));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            pw    <= 1'b0;
        end else begin
            sync1 <= ped_req;
            sync2 <= sync1;
            if (advance && next_state == ST_RED) begin
                pw <= 1'b0;
            end else if (sync2 && state != ST_RED) begin
                pw <= 1'b1;
            end
        end
    end
`else
    logic unused_ped;

    assign unused_ped = ped_req;
    assign ped_go     = 1'b0;
    assign pw         = 1'b0;
`endif

    // Expiry and an early pedestrian exit both collapse into one advance
    assign advance = tick && ((sec_cnt == 8'd0) || ped_go);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_presc (
        .clk (clk),
        .rst (rst),
        .clr (advance),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RED;
            sec_cnt <= R_LD;
        end else if (advance) begin
            state   <= next_state;
            sec_cnt <= next_load;
        end else if (tick) begin
            sec_cnt <= sec_cnt - 8'd1;
        end
    end

    always_comb begin
        lamps = LAMP_RED;
        unique case (state)
            ST_GREEN:  lamps = LAMP_GREEN;
            ST_YELLOW: lamps = LAMP_YELLOW;
            default:   lamps = LAMP_RED;
        endcase
    end

    assign {red_trffc_light, ylw_trffc_light, grn_trffc_light} = lamps;
    assign sec_left    = sec_cnt;
    assign ped_waiting = pw;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Vehicle traffic-light sequencer; sits directly upstream of the crosswalk stage.
- Produces the one-hot red/yellow/green lamp signals; crosswalk consumes red and yellow to drive the walk/stop lamps.
- Fixed-duration GREEN -> YELLOW -> RED cycle, timed in seconds derived from clk by an internal prescaler.
- Optional pedestrian request shortens GREEN.

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second tick; must be >= 2.
- GREEN_SEC, 10: GREEN dwell in ticks; range 1..255.
- YELLOW_SEC, 3: YELLOW dwell in ticks; range 1..255.
- RED_SEC, 8: RED dwell in ticks; range 1..255.
- MIN_GREEN_SEC, 4: minimum GREEN ticks before a pedestrian request may end GREEN; range 1..GREEN_SEC.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- ped_req  input  1  asynchronous pedestrian button, level; used only with PED_REQ_EN.
- red_trffc_light  output  1  red lamp.
- ylw_trffc_light  output  1  yellow lamp.
- grn_trffc_light  output  1  green lamp.
- sec_left  output  8  whole ticks remaining in current state, minus 1 (counts down to 0).
- ped_waiting  output  1  latched pedestrian request pending.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on rising clk.
- States: GREEN, YELLOW, RED; 2-bit encoding; lamp outputs decoded from the state register and exactly one-hot at all times.
- Reset (rst high at a clk edge):
  - state=RED, so red=1, ylw=0, grn=0.
  - prescaler=0; sec_left=RED_SEC-1; ped_waiting=0; synchronizer flops=0.
  - Reset overrides everything, including when asserted mid-state.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when the count equals TICK_DIV-1.
  - Forced to 0 on every state transition, so each state starts on a full tick boundary.
- Second counter (sec_left):
  - Loaded with DUR-1 on entry to a state.
  - On tick: if sec_left==0, transition to the next state and load the next DUR-1; otherwise decrement.
  - Never wraps below 0.
- Transitions: GREEN->YELLOW, YELLOW->RED, RED->GREEN.
- Dwell per state is exactly DUR*TICK_DIV cycles.
- The first RED after reset lasts RED_SEC*TICK_DIV cycles, counted from the first cycle with rst low.
- Full period is (GREEN_SEC+YELLOW_SEC+RED_SEC)*TICK_DIV cycles.
- Lamp outputs change on the clk edge that consumes the final tick; there is no extra pipeline delay.
- Out-of-range parameters are rejected at elaboration via a generate-time error.

Optional Feature:
- Macro: TRAFFIC_PED_REQ_EN.
- Defined:
  - ped_req passes through a 2-flop synchronizer, giving 2 cycles of latency.
  - A synchronized high sets ped_waiting while state is GREEN or YELLOW; requests in RED are ignored.
  - ped_waiting clears on entry to RED.
  - In GREEN, on a tick with ped_waiting=1 and elapsed ticks (GREEN_SEC-sec_left) >= MIN_GREEN_SEC, transition to YELLOW immediately.
  - A request and a natural expiry on the same tick resolve to a single transition to YELLOW.
- Undefined:
  - ped_req is ignored and ped_waiting is tied to 0.
  - No synchronizer flops are instantiated.

Decomposition:
- Package traffic_pkg holds:
  - the state typedef (GREEN/YELLOW/RED encodings);
  - the lamp one-hot constants;
  - a helper function computing the prescaler width as clog2(TICK_DIV).
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst, clr, tick) is the natural split; the FSM, second counter and request latch stay in the top level.

Test Plan:
- Bench parameters: TICK_DIV=4, GREEN_SEC=3, YELLOW_SEC=2, RED_SEC=2, MIN_GREEN_SEC=1.
- Reset: rst high 3 cycles -> red=1, ylw=0, grn=0, sec_left=1; after release, RED for 8 cycles, then GREEN 12, YELLOW 8, RED 8; period 28, repeating.
- Reset mid-operation: rst asserted at YELLOW cycle 3 -> next edge red=1, sec_left=1, prescaler 0; RED then lasts a full 8 cycles after release.
- Pedestrian request (TRAFFIC_PED_REQ_EN): 1-cycle ped_req pulse at GREEN cycle 0 -> ped_waiting=1 by cycle 3; YELLOW from GREEN cycle 4 (GREEN lasts 4 cycles, not 12); ped_waiting=0 on RED entry.
- Request ignored: with the macro, ped_req held high only during RED -> ped_waiting stays 0 and the next GREEN lasts the full 12 cycles. Without the macro, ped_req held high for 100 cycles -> period stays 28 and ped_waiting=0 throughout.
- Invariants: over 1000 random cycles with random ped_req and rst pulses, assertions hold:
  - lamp outputs are always exactly one-hot;
  - sec_left <= current DUR-1;
  - no GREEN->RED or RED->YELLOW transitions ever occur.
